// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: default bus widths
// (kept in one place so the controller and the memory agree) and the FSM
// state encoding.
package mem_access_ctrl_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDRESS   = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_FETCH = 3'd2,
    RD_DRIVE = 3'd3,
    RESP     = 3'd4
  } state_e;

  // Memory chip select is asserted in every state that talks to the memory.
  function automatic logic mem_active(input state_e s);
    return (s == WRITE) || (s == RD_FETCH) || (s == RD_DRIVE);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Request-side controller for the 16-word single-port memory with a shared
// bidirectional data bus. Turns a valid/ready request stream into the
// memory's cs / write_en / read_en sequencing (one-cycle write, two-phase
// read) and returns read data on a valid/ready response port. One
// transaction is in flight at a time.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int data_size = DEF_DATA_SIZE,
  parameter int address   = DEF_ADDRESS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [address-1:0]   req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [data_size-1:0] rsp_rdata,
  output logic [address-1:0]   mem_addr,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic                 mem_re,
  inout  wire  [data_size-1:0] mem_data
);

  state_e               state_q, state_d;
  logic [address-1:0]   addr_q, addr_d;
  logic [data_size-1:0] wdata_q, wdata_d;
  logic [data_size-1:0] rdata_q, rdata_d;
  logic                 cs_q, cs_d;
  logic                 we_q, we_d;
  logic                 re_q, re_d;
  logic                 rsp_valid_q, rsp_valid_d;

  // Next-state, request capture and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_write ? WRITE : RD_FETCH;
        end
      end
      WRITE:    state_d = IDLE;
      RD_FETCH: state_d = RD_DRIVE;
      RD_DRIVE: begin
        // Memory is driving the bus this cycle; capture its word.
        rdata_d = mem_data;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered and line up with that state's cycle.
    cs_d        = mem_active(state_d);
    we_d        = (state_d == WRITE);
    re_d        = (state_d == RD_DRIVE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;

  // The controller drives the bus only while writing; the memory drives it
  // only while read_en is high, which never coincides with WRITE.
  assign mem_data = (state_q == WRITE) ? wdata_q : {data_size{1'bz}};

  // A request with an unknown direction cannot be decoded.
  a_req_write_known: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> !$isunknown(req_write));

  // Write and read enables are mutually exclusive.
  a_we_re_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem_we && mem_re));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural single-port memory
// on the shared bus and a scoreboard of expected read data.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int DW = DEF_DATA_SIZE;
  localparam int AW = DEF_ADDRESS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_cs, mem_we, mem_re;
  // Weak pulldown: a released bus reads as all zeros in any simulator.
  tri0  [DW-1:0] mem_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] shadow [16];   // expected memory contents
  logic [DW-1:0] sb [$];        // expected read responses, in order

  mem_access_ctrl #(.data_size(DW), .address(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: write on cs&we, latch word on cs with no enables,
  // drive the latched word while cs&re.
  logic [DW-1:0] mem_arr [16];
  logic [DW-1:0] rd_latch = '0;
  initial for (int i = 0; i < 16; i++) mem_arr[i] = '0;
  always @(posedge clk) begin
    if (mem_cs && mem_we)       mem_arr[mem_addr] <= mem_data;
    else if (mem_cs && !mem_re) rd_latch <= mem_arr[mem_addr];
  end
  assign mem_data = (mem_cs && mem_re) ? rd_latch : {DW{1'bz}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus-level monitor and response scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("we_re_excl", {31'd0, mem_we & mem_re}, 0);
      check("bus_no_x", {31'd0, $isunknown(mem_data)}, 0);
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", {31'd0, sb.size() > 0}, 1);
        if (sb.size() > 0) check("rsp_rdata", rsp_rdata, sb.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_timeout", req_ready, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    shadow[a] = d;
    check("wr_we", mem_we, 1);
    check("wr_cs", mem_cs, 1);
    check("wr_re", mem_re, 0);
    check("wr_addr", mem_addr, a);
    check("wr_bus", mem_data, d);
    check("wr_busy", req_ready, 0);
    tick();
    check("wr_we_1cyc", mem_we, 0);
    check("wr_ready_back", req_ready, 1);
  endtask

  // Read with `hold` cycles of response backpressure; with `pend`, a write
  // of 8'h99 to addr 9 is held on the request port during backpressure.
  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit pend);
    logic [DW-1:0] exp;
    exp = shadow[a];
    wait_ready();
    sb.push_back(exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    check("rf_cs", mem_cs, 1);
    check("rf_we", mem_we, 0);
    check("rf_re", mem_re, 0);
    check("rf_addr", mem_addr, a);
    check("rf_bus_released", mem_data, 0);
    check("rf_busy", req_ready, 0);
    tick();
    check("rd_re", mem_re, 1);
    check("rd_cs", mem_cs, 1);
    check("rd_no_rsp_yet", rsp_valid, 0);
    tick();
    check("rsp_lat3", rsp_valid, 1);
    check("rsp_mem_idle", {29'd0, mem_cs, mem_we, mem_re}, 0);
    check("rsp_busy", req_ready, 0);
    if (pend) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = 8'h99;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, exp);
      check("bp_busy", req_ready, 0);
      check("bp_no_accept", mem_we, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("rsp_ready_back", req_ready, 1);
    if (pend) begin
      shadow[9] = 8'h99;
      tick();
      req_valid = 1'b0; req_write = 1'b0;
      check("pend_we", mem_we, 1);
      check("pend_addr", mem_addr, 9);
      check("pend_bus", mem_data, 8'h99);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [4];
    int idx;
    int n;
    bit take;
    logic [AW-1:0] op_addr [4];
    logic [DW-1:0] op_data [4];
    bit            op_wr   [4];

    for (int i = 0; i < 16; i++) shadow[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;

    // Reset held for two edges.
    tick(); tick();
    rst = 1'b0;
    check("rst_mem_ctl", {29'd0, mem_cs, mem_we, mem_re}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_bus", mem_data, 0);
    mon_en = 1'b1;

    // Write then read back.
    do_write(4'd3, 8'hA5);
    do_read(4'd3, 0, 1'b0);

    // Full sweep and wrap back to address 0.
    for (int i = 0; i < 16; i++) do_write(i[3:0], 8'(i * 17));
    for (int i = 0; i <= 16; i++) do_read(i[3:0], 0, 1'b0);

    // Response backpressure with a request held during it.
    do_read(4'd7, 5, 1'b1);
    do_read(4'd9, 0, 1'b0);

    // Back-to-back W,W,R,R with req_valid held and rsp_ready high.
    op_wr[0] = 1; op_addr[0] = 4'd1; op_data[0] = 8'h5E;
    op_wr[1] = 1; op_addr[1] = 4'd2; op_data[1] = 8'h6F;
    op_wr[2] = 0; op_addr[2] = 4'd1; op_data[2] = 8'h00;
    op_wr[3] = 0; op_addr[3] = 4'd2; op_data[3] = 8'h00;
    idx = 0; n = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = op_wr[0]; req_addr = op_addr[0]; req_wdata = op_data[0];
    while (idx < 4 && n < 40) begin
      take = req_ready;
      if (take) begin
        if (op_wr[idx]) shadow[op_addr[idx]] = op_data[idx];
        else            sb.push_back(shadow[op_addr[idx]]);
      end
      tick();
      n++;
      if (take) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 4) begin
          req_write = op_wr[idx]; req_addr = op_addr[idx]; req_wdata = op_data[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_all_accepted", idx, 4);
    if (idx == 4) begin
      check("b2b_ww_gap", acc[1] - acc[0], 2);
      check("b2b_wr_gap", acc[2] - acc[1], 2);
      check("b2b_rr_gap", acc[3] - acc[2], 4);
    end
    repeat (5) tick();
    rsp_ready = 1'b0;
    check("b2b_sb_drained", sb.size(), 0);

    // Reset asserted while the read is in RD_DRIVE.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    tick();              // RD_FETCH
    req_valid = 1'b0;
    tick();              // RD_DRIVE
    check("mid_in_drive", mem_re, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_idle_ready", req_ready, 1);
    check("mid_mem_ctl", {29'd0, mem_cs, mem_we, mem_re}, 0);
    check("mid_bus", mem_data, 0);
    for (int i = 0; i < 4; i++) begin
      check("mid_no_rsp", rsp_valid, 0);
      tick();
    end
    do_write(4'd3, 8'h3C);
    do_read(4'd3, 0, 1'b0);

    check("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
